// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline types and constants for the fetch stage and IF/ID register
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD,
        HELD
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus
// Ports: imemReq/imemAddr driven by the fetch stage (master); imemRdata/imemValid driven by memory (slave).
interface fetch_stage_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;

    modport master (output imemReq, output imemAddr, input imemRdata, input imemValid);
    modport slave  (input imemReq, input imemAddr, output imemRdata, output imemValid);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register with stall-hold and flush-to-bubble
// Ports: clk/rst; stall holds the entry; flush loads a bubble; entry_in/entry_out are the {pc, inst, valid} bundle.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t entry_in,
    output if_id_t entry_out
);

    if_id_t entry_q, entry_d;

    always_comb entry_d = stall ? entry_q : flush ? IF_ID_BUBBLE : entry_in;

    always_ff @(posedge clk or posedge rst)
        if (rst) entry_q <= IF_ID_BUBBLE;
        else     entry_q <= entry_d;

    assign entry_out = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with one outstanding imem request, skid buffer and IF/ID register
// Ports: clk/rst; stall, redirect, redirectPc from hazard unit/decode; imem master bus;
//        pcOut/instOut/validOut drive decode through IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirectPc,
    fetch_stage_if.master imem,
    output logic [31:0]   pcOut,
    output logic [31:0]   instOut,
    output logic          validOut
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  skid_inst_q, skid_inst_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    if_id_t       if_id_in, if_id_out;
    logic         r;
    logic [31:0]  tgt;
    logic [31:0]  pc_inc;

    assign r      = redirect & ~stall;
    assign tgt    = redirectPc & ~32'h3;
    assign pc_inc = pc_q + 32'd4;

    // pc always names the next address to fetch; in WAIT it equals req_addr.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if_id_in    = IF_ID_BUBBLE;
        case (state_q)
            IDLE: begin
                req_addr_d = pc_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (imem.imemValid) begin
                    if (r) begin
                        pc_d       = tgt;
                        req_addr_d = tgt;
                    end else if (stall) begin
                        skid_inst_d = imem.imemRdata;
                        skid_pc_d   = req_addr_q + 32'd4;
                        pc_d        = pc_inc;
                        state_d     = HELD;
                    end else begin
                        if_id_in   = '{pc: req_addr_q + 32'd4, inst: imem.imemRdata, valid: 1'b1};
                        pc_d       = pc_inc;
                        req_addr_d = pc_inc;
                    end
                end else if (r) begin
                    pc_d    = tgt;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // The stale response still has to drain before the new address can go out.
                pc_d = r ? tgt : pc_q;
                if (imem.imemValid) begin
                    req_addr_d = pc_d;
                    state_d    = WAIT;
                end
            end
            HELD: begin
                if (!stall) begin
                    pc_d       = r ? tgt : pc_q;
                    req_addr_d = pc_d;
                    state_d    = WAIT;
                    if (!r) if_id_in = '{pc: skid_pc_q, inst: skid_inst_q, valid: 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end

    fetch_stage_if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (r),
        .entry_in (if_id_in),
        .entry_out(if_id_out)
    );

    assign imem.imemReq  = (state_q == WAIT) || (state_q == DISCARD);
    assign imem.imemAddr = req_addr_q;
    assign pcOut         = if_id_out.pc;
    assign instOut       = if_id_out.inst;
    assign validOut      = if_id_out.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        validOut;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .redirect  (redirect),
        .redirectPc(redirectPc),
        .imem      (imem),
        .pcOut     (pcOut),
        .instOut   (instOut),
        .validOut  (validOut)
    );

    always #5 clk = ~clk;

    int          nchecks = 0;
    int          nerrors = 0;
    int          deliveries = 0;
    int          fixed_lat = 0;
    logic [31:0] key = 32'h0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset;
        chk("rst_req", 32'(imem.imemReq), 32'd0);
        chk("rst_addr", imem.imemAddr, 32'h0);
        chk("rst_pc", pcOut, 32'h0);
        chk("rst_inst", instOut, 32'h0);
        chk("rst_valid", 32'(validOut), 32'd0);
    endtask

    // Memory: one response per request, latency fixed_lat (or random 0..3 when negative).
    initial begin
        logic        pending;
        int          cnt;
        logic [31:0] maddr;
        pending = 1'b0;
        cnt = 0;
        maddr = 32'h0;
        imem.imemValid = 1'b0;
        imem.imemRdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pending = 1'b0;
                imem.imemValid = 1'b0;
            end else begin
                if (imem.imemValid) pending = 1'b0;
                imem.imemValid = 1'b0;
                if (pending) begin
                    chk("mem_req_held", 32'(imem.imemReq), 32'd1);
                    chk("mem_addr_stable", imem.imemAddr, maddr);
                end else if (imem.imemReq) begin
                    pending = 1'b1;
                    maddr = imem.imemAddr;
                    cnt = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (pending) begin
                    if (cnt == 0) begin
                        imem.imemValid = 1'b1;
                        imem.imemRdata = memf(maddr);
                    end else cnt--;
                end
            end
        end
    end

    // Scoreboard: the architectural path is RESET_PC, +4, ... restarted at each effective redirect target.
    initial begin
        logic        s, rr;
        logic [31:0] t, a;
        logic [31:0] last_pc, last_inst;
        logic        last_valid;
        exp_q.push_back(32'h0);
        last_pc = 32'h0;
        last_inst = 32'h0;
        last_valid = 1'b0;
        forever begin
            @(posedge clk);
            s = stall;
            rr = redirect & ~stall;
            t = redirectPc & ~32'h3;
            #2;
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(32'h0);
            end else if (rr) begin
                chk("sb_bubble", 32'(validOut), 32'd0);
                exp_q.delete();
                exp_q.push_back(t);
            end else if (s) begin
                chk("sb_hold_pc", pcOut, last_pc);
                chk("sb_hold_inst", instOut, last_inst);
                chk("sb_hold_valid", 32'(validOut), 32'(last_valid));
            end else if (validOut) begin
                a = exp_q.pop_front();
                chk("sb_pc", pcOut, a + 32'd4);
                chk("sb_inst", instOut, memf(a));
                if (exp_q.size() == 0) exp_q.push_back(a + 32'd4);
                deliveries++;
            end
            last_pc = pcOut;
            last_inst = instOut;
            last_valid = validOut;
        end
    end

    initial begin
        logic [31:0] hold;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirectPc = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        tick();
        chk("first_req", 32'(imem.imemReq), 32'd1);
        chk("first_addr", imem.imemAddr, 32'h0);
        chk("first_valid", 32'(validOut), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("zw_pc", pcOut, 32'(4 * k));
            chk("zw_inst", instOut, 32'(4 * (k - 1)));
            chk("zw_valid", 32'(validOut), 32'd1);
        end
        @(negedge clk);
        stall = 1'b1;
        hold = pcOut;
        repeat (3) begin
            tick();
            chk("stall_hold", pcOut, hold);
        end
        @(negedge clk);
        stall = 1'b0;
        tick();
        chk("skid_pc", pcOut, 32'd16);
        chk("skid_inst", instOut, 32'd12);
        tick();
        chk("post_skid_pc", pcOut, 32'd20);
        @(negedge clk);
        redirect = 1'b1;
        redirectPc = 32'h100;
        tick();
        chk("rd_valid_bubble", 32'(validOut), 32'd0);
        chk("rd_valid_addr", imem.imemAddr, 32'h100);
        @(negedge clk);
        redirect = 1'b0;
        tick();
        chk("rd_target_pc", pcOut, 32'h104);
        chk("rd_target_inst", instOut, 32'h100);
        @(negedge clk);
        fixed_lat = 3;
        tick();
        @(negedge clk);
        redirect = 1'b1;
        tick();
        chk("disc_req", 32'(imem.imemReq), 32'd1);
        chk("disc_addr", imem.imemAddr, 32'h108);
        chk("disc_bubble", 32'(validOut), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) begin
            tick();
            chk("disc_addr_hold", imem.imemAddr, 32'h108);
        end
        tick();
        chk("disc_new_addr", imem.imemAddr, 32'h100);
        chk("disc_no_stale", 32'(validOut), 32'd0);
        @(negedge clk);
        fixed_lat = 0;
        repeat (6) tick();
        @(negedge clk);
        stall = 1'b1;
        redirect = 1'b1;
        redirectPc = 32'h300;
        hold = pcOut;
        repeat (2) begin
            tick();
            chk("rs_hold_pc", pcOut, hold);
        end
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        tick();
        chk("rs_seq_pc", pcOut, hold + 32'd4);
        @(negedge clk);
        redirect = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_req_addr", imem.imemAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        redirect = 1'b0;
        tick();
        chk("wrap_pc", pcOut, 32'h0);
        chk("wrap_inst", instOut, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem.imemAddr, 32'h0);
        tick();
        chk("wrap_pc2", pcOut, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        key = 32'h5A5A_C3C3;
        fixed_lat = -1;
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stall = $urandom_range(0, 4) == 0;
            redirect = i > 1 && $urandom_range(0, 7) == 0;
            redirectPc = $urandom;
        end
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        repeat (10) @(negedge clk);
        chk("liveness", 32'(deliveries > 400), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
